mips_alu_exec: RTL and testbench

Execute-stage ALU for the 32-bit MIPS datapath. It is the consumer end of the 4-bit ALU_Ctrl bus driven by ALU_Control: it decodes ALU_Ctrl and performs the operation on two 32-bit operands. Logic ops, add, sub and SLT complete in one cycle. Signed MULT and DIV run as 32-step iterative sequences and write the HI/LO register pair. MFHI and MFLO read HI/LO back onto the result bus.

---
 rtl/mips_alu_exec.sv | 195 +++++++++++++++++++
 tb/tb_mips_alu_exec.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith/SLT/MFHI/MFLO plus iterative
// signed MULT and DIV that write the HI/LO pair.
module mips_alu_exec #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_Ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_by_zero,
  output logic             bad_op
);

  // state | meaning
  // IDLE  | accepting ops; single-cycle ops complete here
  // MUL   | shift-add multiply, one step per cycle
  // DIV   | restoring divide, one step per cycle
  // FIN   | sign fix-up, write HI/LO, pulse done
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  localparam int CW = $clog2(ITER);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  state_t               r_state, w_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opb;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic                 r_is_div;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_res;
  logic                 w_bad;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_shl;
  logic [WIDTH:0]       w_div_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_accept = start && (r_state == S_IDLE);
  assign w_last   = (r_cnt == '0);
  assign busy     = (r_state != S_IDLE);
  assign w_abs_a  = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_abs_b  = B[WIDTH-1] ? (~B + 1'b1) : B;

  always_comb begin
    w_res = '0;
    w_bad = 1'b0;
    case (ALU_Ctrl)
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_ADD:  w_res = A + B;
      OP_NOR:  w_res = ~(A | B);
      OP_SUB:  w_res = A - B;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_MULT: w_res = '0;
      OP_DIV:  w_res = '0;
      OP_MFHI: w_res = HI;
      OP_MFLO: w_res = LO;
      default: w_bad = 1'b1;
    endcase
  end

  // Multiply: conditional add into the upper half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: remainder in the upper half, dividend/quotient in the lower half.
  assign w_div_shl  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff = w_div_shl - {1'b0, r_opb};
  assign w_div_next = w_div_diff[WIDTH]
                    ? {w_div_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_sign_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_sign_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_sign_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                           : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && ALU_Ctrl == OP_MULT)
          w_next = S_MUL;
        else if (w_accept && ALU_Ctrl == OP_DIV && B != '0)
          w_next = S_DIV;
      end
      S_MUL:   if (w_last) w_next = S_FIN;
      S_DIV:   if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result      <= '0;
      Zero        <= 1'b1;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      bad_op      <= 1'b0;
      HI          <= '0;
      LO          <= '0;
      r_acc       <= '0;
      r_opb       <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_is_div    <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      bad_op      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (ALU_Ctrl == OP_MULT || (ALU_Ctrl == OP_DIV && B != '0)) begin
              r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
              r_opb    <= w_abs_b;
              r_sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
              r_sign_r <= A[WIDTH-1];
              r_is_div <= (ALU_Ctrl == OP_DIV);
              r_cnt    <= CW'(ITER - 1);
            end else if (ALU_Ctrl == OP_DIV) begin
              Result      <= '0;
              Zero        <= 1'b1;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              Result <= w_res;
              Zero   <= (w_res == '0);
              done   <= 1'b1;
              bad_op <= w_bad;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIN: begin
          if (r_is_div) begin
            HI <= w_rem;
            LO <= w_quo;
          end else begin
            HI <= w_prod[2*WIDTH-1:WIDTH];
            LO <= w_prod[WIDTH-1:0];
          end
          Result <= '0;
          Zero   <= 1'b1;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_exec.sv
// Directed bench for mips_alu_exec with hand-computed expectations.
module tb_mips_alu_exec;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  ALU_Ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        Zero;
  logic        done;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        div_by_zero;
  logic        bad_op;

  int n_tests = 0;
  int n_fail  = 0;

  mips_alu_exec #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_Ctrl(ALU_Ctrl),
    .A(A), .B(B), .Result(Result), .Zero(Zero), .done(done), .busy(busy),
    .HI(HI), .LO(LO), .div_by_zero(div_by_zero), .bad_op(bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op for one edge; returns #1 after that edge (cycle T+1).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    ALU_Ctrl = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called at cycle T+1; reports the cycle index of done and busy cycles seen.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 1;
    bcnt = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  initial begin
    int cyc, bcnt, extra;
    rst_n = 1'b0;
    start = 1'b0;
    ALU_Ctrl = 4'b0000;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", Result, 32'h0);
    chk("rst_zero", 32'(Zero), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_bad", 32'(bad_op), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single-cycle sweep, issued back to back
    issue(4'b0001, 32'h0000000F, 32'h000000F0);
    chk("or_res", Result, 32'h000000FF);
    chk("or_zero", 32'(Zero), 32'd0);
    chk("or_done", 32'(done), 32'd1);
    issue(4'b0000, 32'h0000000F, 32'h000000F0);
    chk("and_res", Result, 32'h0);
    chk("and_zero", 32'(Zero), 32'd1);
    chk("and_done", 32'(done), 32'd1);
    issue(4'b0011, 32'h0000000F, 32'h000000F0);
    chk("nor_res", Result, 32'hFFFFFF00);
    chk("nor_zero", 32'(Zero), 32'd0);
    issue(4'b0010, 32'hFFFFFFFF, 32'h00000001);
    chk("add_wrap", Result, 32'h0);
    chk("add_zero", 32'(Zero), 32'd1);
    issue(4'b0110, 32'd5, 32'd7);
    chk("sub_res", Result, 32'hFFFFFFFE);
    issue(4'b0111, 32'hFFFFFFFF, 32'd1);
    chk("slt_neg", Result, 32'd1);
    issue(4'b0111, 32'd1, 32'hFFFFFFFF);
    chk("slt_pos", Result, 32'd0);
    chk("slt_done", 32'(done), 32'd1);
    chk("hi_untouched", HI, 32'h0);
    @(posedge clk);
    #1;
    chk("done_drop", 32'(done), 32'd0);
    chk("result_hold", Result, 32'd0);

    // MULT -3 * 0x7FFFFFFF
    issue(4'b1000, 32'hFFFFFFFD, 32'h7FFFFFFF);
    chk("mul_busy1", 32'(busy), 32'd1);
    chk("mul_nodone", 32'(done), 32'd0);
    wait_done(cyc, bcnt);
    chk("mul_cycle", 32'(cyc), 32'd34);
    chk("mul_busycnt", 32'(bcnt), 32'd33);
    chk("mul_hi", HI, 32'hFFFFFFFE);
    chk("mul_lo", LO, 32'h80000003);
    chk("mul_result", Result, 32'h0);
    chk("mul_busy_end", 32'(busy), 32'd0);
    issue(4'b1010, 32'h0, 32'h0);
    chk("mfhi", Result, 32'hFFFFFFFE);
    issue(4'b1011, 32'h0, 32'h0);
    chk("mflo", Result, 32'h80000003);

    // DIV -7 / 2
    issue(4'b1001, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, bcnt);
    chk("div_cycle", 32'(cyc), 32'd34);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    chk("div_dbz0", 32'(div_by_zero), 32'd0);

    // DIV by zero
    issue(4'b1001, 32'd7, 32'd0);
    chk("dbz_done", 32'(done), 32'd1);
    chk("dbz_flag", 32'(div_by_zero), 32'd1);
    chk("dbz_busy", 32'(busy), 32'd0);
    chk("dbz_hi", HI, 32'hFFFFFFFF);
    chk("dbz_lo", LO, 32'hFFFFFFFD);
    @(posedge clk);
    #1;
    chk("dbz_clear", 32'(div_by_zero), 32'd0);

    // most-negative / -1 wraps
    issue(4'b1001, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, bcnt);
    chk("ovf_lo", LO, 32'h80000000);
    chk("ovf_hi", HI, 32'h0);

    // start held while DIV is busy must be ignored
    issue(4'b1001, 32'd100, 32'd7);
    extra = 0;
    start = 1'b1;
    ALU_Ctrl = 4'b0010;
    A = 32'd1;
    B = 32'd1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    start = 1'b0;
    wait_done(cyc, bcnt);
    chk("ign_extra_done", 32'(extra), 32'd0);
    chk("ign_lo", LO, 32'd14);
    chk("ign_hi", HI, 32'd2);
    chk("ign_result", Result, 32'h0);

    // unassigned opcode
    issue(4'b0010, 32'd1, 32'd1);
    chk("add_pre_bad", Result, 32'd2);
    issue(4'b1111, 32'h12345678, 32'h9ABCDEF0);
    chk("bad_result", Result, 32'h0);
    chk("bad_flag", 32'(bad_op), 32'd1);
    chk("bad_zero", 32'(Zero), 32'd1);
    chk("bad_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    chk("bad_clear", 32'(bad_op), 32'd0);

    // reset in the middle of a MULT
    issue(4'b0010, 32'd3, 32'd4);
    chk("add_pre_rst", Result, 32'd7);
    issue(4'b1000, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_hi", HI, 32'h0);
    chk("mrst_lo", LO, 32'h0);
    chk("mrst_result", Result, 32'h0);
    chk("mrst_zero", 32'(Zero), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(4'b0010, 32'd2, 32'd3);
    chk("post_add", Result, 32'd5);
    issue(4'b1000, 32'd5, 32'hFFFFFFFA);
    wait_done(cyc, bcnt);
    chk("post_mul_cycle", 32'(cyc), 32'd34);
    chk("post_mul_hi", HI, 32'hFFFFFFFF);
    chk("post_mul_lo", LO, 32'hFFFFFFE2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
